// File: rtl/popcount_if.sv
// popcount_if: valid/ready word-in, count-out handshake bundle for popcount_seq
//   master (source/sink side): drives in_valid, in_data, in_mode and out_ready
//   slave  (counter side):     drives in_ready, out_valid, out_count and the flags
interface popcount_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH + 1);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_parity;
  logic             out_all;
  logic             out_none;
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_parity, out_all, out_none
  );
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_parity, out_all, out_none
  );
endinterface

// File: rtl/popcount_seq.sv
// popcount_seq: multi-cycle one/zero counter, CHUNK bits per clock, with saturating running total
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : word in (in_valid/in_ready/in_data/in_mode), result out
//                     (out_valid/out_ready/out_count/out_parity/out_all/out_none)
//   clear           : synchronous clear of total/total_sat
//   total/total_sat : saturating sum of delivered counts, sticky clip flag
module popcount_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  popcount_if.slave        bus,
  input  logic             clear,
  output logic [ACC_W-1:0] total,
  output logic             total_sat
);
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int NSTEP = WIDTH / CHUNK;
  localparam int SW    = NSTEP > 1 ? $clog2(NSTEP) : 1;
  localparam int TW    = (ACC_W > CW ? ACC_W : CW) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  generate
    if (WIDTH < 1 || CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad
      $error("popcount_seq: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate
  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    acc, pc, sum, count;
  logic [SW-1:0]    step;
  logic             valid, parity, all_f, none_f;
  logic             accept, hs_out, ovf;
  logic [TW-1:0]    t_sum;
  assign bus.in_ready   = state == IDLE || (state == DONE && bus.out_ready);
  assign bus.out_valid  = valid;
  assign bus.out_count  = count;
  assign bus.out_parity = parity;
  assign bus.out_all    = all_f;
  assign bus.out_none   = none_f;
  assign accept = bus.in_valid && bus.in_ready;
  assign hs_out = valid && bus.out_ready;
  always_comb begin
    pc = '0;
    for (int i = 0; i < CHUNK; i++) pc = pc + CW'(shreg[i]);
  end
  assign sum = acc + pc;
  // clear during a handshake restarts the total from this single count
  assign t_sum = TW'(clear ? '0 : total) + TW'(count);
  assign ovf   = t_sum > TW'({ACC_W{1'b1}});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= '0;
      step      <= '0;
      valid     <= 1'b0;
      count     <= '0;
      parity    <= 1'b0;
      all_f     <= 1'b0;
      none_f    <= 1'b0;
      total     <= '0;
      total_sat <= 1'b0;
    end else begin
      if (accept) begin
        shreg <= bus.in_mode ? ~bus.in_data : bus.in_data;
        acc   <= '0;
        step  <= '0;
        valid <= 1'b0;
        state <= SCAN;
      end else if (state == SCAN) begin
        shreg <= shreg >> CHUNK;
        acc   <= sum;
        step  <= step + 1'b1;
        if (step == SW'(NSTEP - 1)) begin
          count  <= sum;
          parity <= sum[0];
          all_f  <= sum == CW'(WIDTH);
          none_f <= sum == '0;
          valid  <= 1'b1;
          state  <= DONE;
        end
      end else if (hs_out) begin
        valid <= 1'b0;
        state <= IDLE;
      end
      if (hs_out) begin
        total     <= ovf ? {ACC_W{1'b1}} : t_sum[ACC_W-1:0];
        total_sat <= (!clear && total_sat) || ovf;
      end else if (clear) begin
        total     <= '0;
        total_sat <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_popcount_seq.sv
// tb_popcount_seq: directed table plus handshake corner sequences for popcount_seq (ACC_W 16 and 6)
module tb_popcount_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] total16;
  logic        sat16;
  logic [5:0]  total6;
  logic        sat6;
  int          compared = 0;
  int          mismatched = 0;
  int          t16, t6, lat;
  bit          s16, s6;
  popcount_if #(.WIDTH(32)) a ();
  popcount_if #(.WIDTH(32)) b ();
  assign b.in_valid  = a.in_valid;
  assign b.in_data   = a.in_data;
  assign b.in_mode   = a.in_mode;
  assign b.out_ready = a.out_ready;
  popcount_seq #(.WIDTH(32), .CHUNK(8), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(a), .clear(clear), .total(total16), .total_sat(sat16));
  popcount_seq #(.WIDTH(32), .CHUNK(8), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(b), .clear(clear), .total(total6), .total_sat(sat6));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] data;
    logic        mode;
    int          cnt;
    logic        par;
    logic        all;
    logic        none;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!a.out_valid && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      mismatched++;
      $display("FAIL wait_out_valid: got timeout expected out_valid within 20 cycles");
    end
  endtask
  function automatic void hs_model(input int cnt, input bit clr);
    int s;
    s   = (clr ? 0 : t16) + cnt;
    s16 = (clr ? 1'b0 : s16) | (s > 65535);
    t16 = s > 65535 ? 65535 : s;
    s   = (clr ? 0 : t6) + cnt;
    s6  = (clr ? 1'b0 : s6) | (s > 63);
    t6  = s > 63 ? 63 : s;
  endfunction
  task automatic chk_totals(input string nm);
    chk({nm, "_total16"}, total16, t16);
    chk({nm, "_sat16"}, sat16, s16);
    chk({nm, "_total6"}, total6, t6);
    chk({nm, "_sat6"}, sat6, s6);
  endtask
  task automatic run_vec(input vec_t v);
    a.in_valid  = 1'b1;
    a.in_data   = v.data;
    a.in_mode   = v.mode;
    a.out_ready = 1'b1;
    chk("in_ready_idle", a.in_ready, 1);
    step();
    a.in_valid = 1'b0;
    wait_valid(lat);
    chk("latency", lat, 4);
    chk("out_count", a.out_count, v.cnt);
    chk("out_parity", a.out_parity, v.par);
    chk("out_all", a.out_all, v.all);
    chk("out_none", a.out_none, v.none);
    chk("dut6_count", b.out_count, v.cnt);
    step();
    hs_model(v.cnt, 1'b0);
    chk("out_valid_drop", a.out_valid, 0);
    chk_totals("vec");
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 ns");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 1'b0, 32, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0001, 1'b1, 31, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 1'b1, 0,  1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0000, 1'b0, 0,  1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h1234_5678, 1'b0, 13, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h8000_0001, 1'b1, 30, 1'b0, 1'b0, 1'b0};
    t16 = 0; t6 = 0; s16 = 0; s6 = 0;
    rst_n = 1'b0; clear = 1'b0;
    a.in_valid = 1'b0; a.in_data = '0; a.in_mode = 1'b0; a.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", a.in_ready, 1);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_out_count", a.out_count, 0);
    chk("rst_flags", {a.out_parity, a.out_all, a.out_none}, 0);
    chk_totals("rst");
    step();
    step();
    rst_n = 1'b1;
    step();
    foreach (vecs[i]) run_vec(vecs[i]);
    // backpressure: result held while out_ready is low
    a.in_valid = 1'b1; a.in_data = 32'h0F0F_0F0F; a.in_mode = 1'b0; a.out_ready = 1'b0;
    step();
    a.in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_latency", lat, 4);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", a.out_valid, 1);
      chk("bp_out_count", a.out_count, 16);
      chk("bp_in_ready", a.in_ready, 0);
      chk("bp_total16", total16, t16);
      step();
    end
    a.out_ready = 1'b1;
    step();
    hs_model(16, 1'b0);
    chk("bp_out_valid_drop", a.out_valid, 0);
    chk_totals("bp");
    // back-to-back: next word accepted on the result handshake edge
    a.in_valid = 1'b1; a.in_data = 32'hA5A5_A5A5;
    step();
    wait_valid(lat);
    chk("b2b_count1", a.out_count, 16);
    chk("b2b_in_ready_done", a.in_ready, 1);
    a.in_data = 32'h0000_00FF;
    step();
    hs_model(16, 1'b0);
    chk("b2b_out_valid_drop", a.out_valid, 0);
    chk("b2b_in_ready_scan", a.in_ready, 0);
    chk_totals("b2b1");
    wait_valid(lat);
    chk("b2b_spacing", lat + 1, 5);
    chk("b2b_count2", a.out_count, 8);
    a.in_valid = 1'b0;
    step();
    hs_model(8, 1'b0);
    chk_totals("b2b2");
    // clear coinciding with a handshake restarts total from this count
    a.in_valid = 1'b1; a.in_data = 32'h0000_000F;
    step();
    a.in_valid = 1'b0;
    wait_valid(lat);
    clear = 1'b1;
    step();
    clear = 1'b0;
    hs_model(4, 1'b1);
    chk("clr_total6", total6, 4);
    chk("clr_sat6", sat6, 0);
    chk_totals("clr_hs");
    // asynchronous reset two cycles into a scan
    a.in_valid = 1'b1; a.in_data = 32'h00FF_00FF;
    step();
    a.in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    t16 = 0; t6 = 0; s16 = 0; s6 = 0;
    chk("mid_rst_out_valid", a.out_valid, 0);
    chk("mid_rst_in_ready", a.in_ready, 1);
    chk_totals("mid_rst");
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", a.in_ready, 1);
    run_vec('{32'h0000_0001, 1'b0, 1, 1'b1, 1'b0, 1'b0});
    // standalone clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    t16 = 0; t6 = 0; s16 = 0; s6 = 0;
    chk_totals("clr_only");
    chk("clr_out_count_kept", a.out_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
